// File: rtl/set_key_pkg.sv
// set_key_pkg: set-mode state encoding, select codes and the mode-step and select-decode helpers shared by set_key_ctrl
package set_key_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLK_HOUR = 3'd1,
    CLK_MIN  = 3'd2,
    ALM_HOUR = 3'd3,
    ALM_MIN  = 3'd4
  } state_e;
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_HOUR = 2'b01;
  localparam logic [1:0] SEL_MIN  = 2'b10;
  function automatic state_e next_mode(input state_e s);
    return s == IDLE     ? CLK_HOUR :
           s == CLK_HOUR ? CLK_MIN  :
           s == CLK_MIN  ? ALM_HOUR :
           s == ALM_HOUR ? ALM_MIN  : IDLE;
  endfunction
  function automatic logic [1:0] clk_sel(input state_e s);
    return s == CLK_HOUR ? SEL_HOUR : s == CLK_MIN ? SEL_MIN : SEL_NONE;
  endfunction
  function automatic logic [1:0] alm_sel(input state_e s);
    return s == ALM_HOUR ? SEL_HOUR : s == ALM_MIN ? SEL_MIN : SEL_NONE;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop sync + debounce of key_raw into key_level, one-cycle press on accepted rise; a key held through cr must be released before it can press
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_50m,
  input  logic cr,
  input  logic key_raw,
  output logic key_level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;
  logic          flip;
  always_comb begin
    sync_d  = {sync_q[0], key_raw};
    flip    = (sync_q[1] != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    cnt_d   = (sync_q[1] == level_q || flip) ? '0 : cnt_q + 1'b1;
    level_d = flip ? ~level_q : level_q;
    armed_d = armed_q | ~sync_q[1];
    press_d = flip & ~level_q & armed_q;
  end
  always_ff @(posedge clk_50m) begin
    sync_q <= sync_d;
    if (!cr) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end
  assign key_level = level_q;
  assign press     = press_q;
endmodule

// File: rtl/set_key_ctrl.sv
// set_key_ctrl: debounced mode/ok keys step the set-mode FSM; drives clock_set_select/alarm_set_select/set_active and a stretched confirm, with inactivity timeout to IDLE
module set_key_ctrl
  import set_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int CONFIRM_HOLD_CYCLES = 75_000_000,
  parameter int TIMEOUT_CYCLES      = 500_000_000
) (
  input  logic       clk_50m,
  input  logic       cr,
  input  logic       key_mode,
  input  logic       key_ok,
  output logic [1:0] clock_set_select,
  output logic [1:0] alarm_set_select,
  output logic       confirm,
  output logic       set_active
);
  localparam int HW = $clog2(CONFIRM_HOLD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic          mode_level, mode_press, ok_level, ok_press, mode, ok;
  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] to_q, to_d;
  logic          conf_q, conf_d;
  logic [1:0]    csel_q, csel_d, asel_q, asel_d;
  logic          active_q, active_d;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk_50m  (clk_50m),
    .cr       (cr),
    .key_raw  (key_mode),
    .key_level(mode_level),
    .press    (mode_press)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ok (
    .clk_50m  (clk_50m),
    .cr       (cr),
    .key_raw  (key_ok),
    .key_level(ok_level),
    .press    (ok_press)
  );
  always_comb begin
    mode    = mode_press & mode_level;
    ok      = ok_press & ok_level;
    state_d = state_q;
    conf_d  = conf_q;
    hold_d  = hold_q;
    to_d    = (state_q == IDLE || mode || ok) ? '0 : to_q + 1'b1;
    if (mode) begin
      state_d = next_mode(state_q);
      conf_d  = 1'b0;
      hold_d  = '0;
    end else if (to_d == TW'(TIMEOUT_CYCLES)) begin
      state_d = IDLE;
      conf_d  = 1'b0;
      hold_d  = '0;
      to_d    = '0;
    end else if (conf_q) begin
      conf_d = hold_q != HW'(CONFIRM_HOLD_CYCLES);
      hold_d = conf_d ? hold_q + 1'b1 : '0;
    end else if (ok && state_q != IDLE) begin
      conf_d = 1'b1;
      hold_d = HW'(1);
    end
    csel_d   = clk_sel(state_d);
    asel_d   = alm_sel(state_d);
    active_d = state_d != IDLE;
  end
  always_ff @(posedge clk_50m) begin
    if (!cr) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      to_q     <= '0;
      conf_q   <= 1'b0;
      csel_q   <= SEL_NONE;
      asel_q   <= SEL_NONE;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      to_q     <= to_d;
      conf_q   <= conf_d;
      csel_q   <= csel_d;
      asel_q   <= asel_d;
      active_q <= active_d;
    end
  end
  assign clock_set_select = csel_q;
  assign alarm_set_select = asel_q;
  assign confirm          = conf_q;
  assign set_active       = active_q;
endmodule

// File: tb/tb_set_key_ctrl.sv
// tb_set_key_ctrl: directed self-checking bench for set_key_ctrl with DEBOUNCE=4, HOLD=8, TIMEOUT=64
module tb_set_key_ctrl;
  logic       clk_50m = 1'b0;
  logic       cr = 1'b0;
  logic       key_mode = 1'b0;
  logic       key_ok = 1'b0;
  logic [1:0] clock_set_select, alarm_set_select;
  logic       confirm, set_active;
  int         checks = 0;
  int         errors = 0;
  always #5 clk_50m = ~clk_50m;
  set_key_ctrl #(
    .DEBOUNCE_CYCLES    (4),
    .CONFIRM_HOLD_CYCLES(8),
    .TIMEOUT_CYCLES     (64)
  ) dut (
    .clk_50m         (clk_50m),
    .cr              (cr),
    .key_mode        (key_mode),
    .key_ok          (key_ok),
    .clock_set_select(clock_set_select),
    .alarm_set_select(alarm_set_select),
    .confirm         (confirm),
    .set_active      (set_active)
  );
  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask
  task automatic chk_o(input string tag, input logic [5:0] exp);
    chk(tag, {clock_set_select, alarm_set_select, confirm, set_active}, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk_50m);
  endtask
  task automatic key_down(input logic m, input logic o);
    key_mode = m;
    key_ok   = o;
    tick(7);
  endtask
  task automatic key_up();
    key_mode = 1'b0;
    key_ok   = 1'b0;
    tick(8);
  endtask
  task automatic press(input logic m, input logic o);
    key_down(m, o);
    key_up();
  endtask
  task automatic rst();
    cr = 1'b0;
    tick(2);
    cr = 1'b1;
    tick(1);
  endtask
  initial begin
    tick(3);
    chk_o("reset", 6'b00_00_0_0);
    cr = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      key_mode = 1'b1;
      tick(2);
      key_mode = 1'b0;
      tick(2);
    end
    chk_o("bounce_none", 6'b00_00_0_0);
    key_mode = 1'b1;
    tick(6);
    chk_o("bounce_e6", 6'b00_00_0_0);
    tick(1);
    chk_o("bounce_e7", 6'b01_00_0_1);
    tick(23);
    chk_o("held_once", 6'b01_00_0_1);
    key_mode = 1'b0;
    tick(8);
    rst();
    key_down(1'b1, 1'b0); chk_o("cyc1", 6'b01_00_0_1); key_up();
    key_down(1'b1, 1'b0); chk_o("cyc2", 6'b10_00_0_1); key_up();
    key_down(1'b1, 1'b0); chk_o("cyc3", 6'b00_01_0_1); key_up();
    key_down(1'b1, 1'b0); chk_o("cyc4", 6'b00_10_0_1); key_up();
    key_down(1'b1, 1'b0); chk_o("cyc5", 6'b00_00_0_0); key_up();
    rst();
    key_down(1'b0, 1'b1);
    chk_o("ok_idle_dn", 6'b00_00_0_0);
    key_up();
    chk_o("ok_idle_up", 6'b00_00_0_0);
    rst();
    press(1'b1, 1'b0);
    key_ok = 1'b1;
    tick(4);
    key_ok = 1'b0;
    tick(2);
    chk_o("conf_e6", 6'b01_00_0_1);
    tick(1);
    chk_o("conf_rise", 6'b01_00_1_1);
    tick(1);
    key_ok = 1'b1;
    tick(4);
    key_ok = 1'b0;
    tick(2);
    chk_o("conf_e14", 6'b01_00_1_1);
    tick(1);
    chk_o("conf_fall", 6'b01_00_0_1);
    tick(10);
    chk_o("conf_noext", 6'b01_00_0_1);
    key_ok = 1'b1;
    tick(3);
    key_mode = 1'b1;
    tick(1);
    key_ok = 1'b0;
    tick(3);
    chk_o("abort_e7", 6'b01_00_1_1);
    tick(2);
    chk_o("abort_e9", 6'b01_00_1_1);
    tick(1);
    chk_o("abort_e10", 6'b10_00_0_1);
    key_mode = 1'b0;
    tick(12);
    key_down(1'b1, 1'b1);
    chk_o("both_dn", 6'b00_01_0_1);
    key_up();
    chk_o("both_up", 6'b00_01_0_1);
    rst();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    key_down(1'b1, 1'b0);
    key_up();
    tick(55);
    chk_o("to_e70", 6'b00_10_0_1);
    tick(1);
    chk_o("to_e71", 6'b00_00_0_0);
    rst();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    key_down(1'b1, 1'b0);
    key_up();
    tick(46);
    key_ok = 1'b1;
    tick(4);
    key_ok = 1'b0;
    tick(6);
    chk_o("to_restart", 6'b00_10_1_1);
    tick(60);
    chk_o("to_e131", 6'b00_10_0_1);
    tick(1);
    chk_o("to_e132", 6'b00_00_0_0);
    rst();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    key_ok = 1'b1;
    tick(4);
    key_ok = 1'b0;
    tick(3);
    chk_o("rst_pre", 6'b10_00_1_1);
    key_mode = 1'b1;
    tick(1);
    cr = 1'b0;
    tick(1);
    chk_o("rst_edge", 6'b00_00_0_0);
    cr = 1'b1;
    tick(20);
    chk_o("rst_held", 6'b00_00_0_0);
    key_mode = 1'b0;
    tick(10);
    chk_o("rst_rel", 6'b00_00_0_0);
    key_down(1'b1, 1'b0);
    chk_o("rst_repress", 6'b01_00_0_1);
    key_up();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
